alu_dmem_unit: RTL and testbench

- Execute/memory datapath slice of the 5-stage MIPS-style pipeline.
- Decodes ALUop/funct into a 4-bit ALU control code and performs the 32-bit ALU operation with an 8-bit status vector.
- Bit 7 of the status vector is the branch-taken zero flag.
- Hosts the data memory, addressed by the ALU result, with a synchronous write port and a combinational read port.

---
 rtl/alu_dmem_unit.sv | 141 ++++++++++++++
 tb/tb_alu_dmem_unit.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/alu_dmem_unit.sv
// Execute/memory slice: ALUop/funct decode, 32-bit ALU with status flags, and word-addressed data memory.
// Define ALU_SHIFT_EN to add SLL/SRL (funct 000000/000010); otherwise those functs decode as invalid.
module alu_dmem_unit #(
  parameter int DEPTH_LOG2 = 6
) (
  input  logic        SYS_clk,
  input  logic        SYS_reset,
  input  logic [1:0]  alu_op,
  input  logic [5:0]  funct,
  input  logic [4:0]  shamt,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [31:0] store_data,
  output logic [3:0]  alu_ctrl,
  output logic [31:0] alu_result,
  output logic [7:0]  alu_status,
  output logic [31:0] read_data
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [3:0] {
    CTRL_AND     = 4'b0000,
    CTRL_OR      = 4'b0001,
    CTRL_ADD     = 4'b0010,
    CTRL_SUB     = 4'b0110,
    CTRL_SLT     = 4'b0111,
    CTRL_SLL     = 4'b1000,
    CTRL_SRL     = 4'b1001,
    CTRL_NOR     = 4'b1100,
    CTRL_INVALID = 4'b1111
  } alu_ctrl_e;

  alu_ctrl_e ctrl;

  always_comb begin
    ctrl = CTRL_INVALID;
    case (alu_op)
      2'b00: ctrl = CTRL_ADD;
      2'b01: ctrl = CTRL_SUB;
      2'b11: ctrl = CTRL_OR;
      2'b10: begin
        case (funct)
          6'b100000: ctrl = CTRL_ADD;
          6'b100010: ctrl = CTRL_SUB;
          6'b100100: ctrl = CTRL_AND;
          6'b100101: ctrl = CTRL_OR;
          6'b101010: ctrl = CTRL_SLT;
          6'b100111: ctrl = CTRL_NOR;
`ifdef ALU_SHIFT_EN
          6'b000000: ctrl = CTRL_SLL;
          6'b000010: ctrl = CTRL_SRL;
`endif
          default:   ctrl = CTRL_INVALID;
        endcase
      end
      default: ctrl = CTRL_INVALID;
    endcase
  end

  assign alu_ctrl = ctrl;

  // SUB carry is the carry-out of a + ~b + 1, so it reads as "no borrow".
  logic [32:0] sum_ext;
  logic [32:0] diff_ext;
  logic        add_ovf;
  logic        sub_ovf;
  logic        less_than;

  assign sum_ext   = {1'b0, src_a} + {1'b0, src_b};
  assign diff_ext  = {1'b0, src_a} + {1'b0, ~src_b} + 33'd1;
  assign add_ovf   = (src_a[31] == src_b[31]) && (sum_ext[31] != src_a[31]);
  assign sub_ovf   = (src_a[31] != src_b[31]) && (diff_ext[31] != src_a[31]);
  assign less_than = $signed(src_a) < $signed(src_b);

`ifdef ALU_SHIFT_EN
  logic [31:0] sll_res;
  logic [31:0] srl_res;
  assign sll_res = src_b << shamt;
  assign srl_res = src_b >> shamt;
`else
  logic unused_shamt;
  assign unused_shamt = ^shamt;
`endif

  logic ovf_flag;
  logic carry_flag;
  logic invalid_flag;

  always_comb begin
    alu_result   = '0;
    ovf_flag     = 1'b0;
    carry_flag   = 1'b0;
    invalid_flag = 1'b0;
    case (ctrl)
      CTRL_ADD: begin
        alu_result = sum_ext[31:0];
        ovf_flag   = add_ovf;
        carry_flag = sum_ext[32];
      end
      CTRL_SUB: begin
        alu_result = diff_ext[31:0];
        ovf_flag   = sub_ovf;
        carry_flag = diff_ext[32];
      end
      CTRL_AND: alu_result = src_a & src_b;
      CTRL_OR:  alu_result = src_a | src_b;
      CTRL_NOR: alu_result = ~(src_a | src_b);
      CTRL_SLT: alu_result = {31'd0, less_than};
`ifdef ALU_SHIFT_EN
      CTRL_SLL: alu_result = sll_res;
      CTRL_SRL: alu_result = srl_res;
`endif
      default:  invalid_flag = 1'b1;
    endcase
  end

  assign alu_status = {(alu_result == 32'd0), alu_result[31], ovf_flag, carry_flag,
                       invalid_flag, 3'b000};

  // Byte address from the ALU; low two bits and bits above the index are dropped, so addresses wrap.
  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] word_idx;

  assign word_idx = alu_result[DEPTH_LOG2+1:2];

  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (mem_write) begin
      mem[word_idx] <= store_data;
    end
  end

  assign read_data = (mem_read && !SYS_reset) ? mem[word_idx] : 32'd0;

endmodule

// File: tb/tb_alu_dmem_unit.sv
// Directed self-checking bench for alu_dmem_unit; expected values are hand-computed constants.
module tb_alu_dmem_unit;

  logic        SYS_clk;
  logic        SYS_reset;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] store_data;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic [7:0]  alu_status;
  logic [31:0] read_data;

  int total;
  int bad;

  alu_dmem_unit #(.DEPTH_LOG2(6)) dut (
    .SYS_clk    (SYS_clk),
    .SYS_reset  (SYS_reset),
    .alu_op     (alu_op),
    .funct      (funct),
    .shamt      (shamt),
    .src_a      (src_a),
    .src_b      (src_b),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .store_data (store_data),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_status (alu_status),
    .read_data  (read_data)
  );

  initial SYS_clk = 1'b0;
  always #5 SYS_clk = ~SYS_clk;

  // Inputs change on the falling edge; outputs are sampled 1ns later, well before the next rising edge.
  task automatic applyStimulus(input logic rst, input logic [1:0] op, input logic [5:0] fn,
                               input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b,
                               input logic mw, input logic mr, input logic [31:0] sd);
    @(negedge SYS_clk);
    SYS_reset  = rst;
    alu_op     = op;
    funct      = fn;
    shamt      = sh;
    src_a      = a;
    src_b      = b;
    mem_write  = mw;
    mem_read   = mr;
    store_data = sd;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkAlu(input string tag, input logic [3:0] c, input logic [31:0] r,
                          input logic [7:0] s);
    checkOutput({tag, "_ctrl"}, {28'd0, alu_ctrl}, {28'd0, c});
    checkOutput({tag, "_result"}, alu_result, r);
    checkOutput({tag, "_status"}, {24'd0, alu_status}, {24'd0, s});
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    SYS_reset  = 1'b1;
    alu_op     = 2'b00;
    funct      = 6'd0;
    shamt      = 5'd0;
    src_a      = 32'd0;
    src_b      = 32'd0;
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    store_data = 32'd0;
    $display("[TB] starting alu_dmem_unit bench");

    applyStimulus(1'b1, 2'b00, 6'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0);
    checkOutput("reset_read_forced", read_data, 32'h0);
    applyStimulus(1'b0, 2'b00, 6'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0);
    checkOutput("post_reset_read", read_data, 32'h0);

    applyStimulus(1'b0, 2'b10, 6'b100000, 5'd0, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 32'h0);
    checkAlu("add_ovf", 4'b0010, 32'h80000000, 8'h60);
    applyStimulus(1'b0, 2'b00, 6'd0, 5'd0, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 32'h0);
    checkAlu("add_carry", 4'b0010, 32'h0, 8'h90);

    applyStimulus(1'b0, 2'b01, 6'd0, 5'd0, 32'h1234, 32'h1234, 1'b0, 1'b0, 32'h0);
    checkAlu("beq_equal", 4'b0110, 32'h0, 8'h90);
    applyStimulus(1'b0, 2'b01, 6'd0, 5'd0, 32'h5, 32'h6, 1'b0, 1'b0, 32'h0);
    checkAlu("beq_borrow", 4'b0110, 32'hFFFFFFFF, 8'h40);
    applyStimulus(1'b0, 2'b01, 6'd0, 5'd0, 32'h80000000, 32'h1, 1'b0, 1'b0, 32'h0);
    checkAlu("sub_ovf", 4'b0110, 32'h7FFFFFFF, 8'h30);

    applyStimulus(1'b0, 2'b10, 6'b101010, 5'd0, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 32'h0);
    checkAlu("slt_neg", 4'b0111, 32'h1, 8'h00);
    applyStimulus(1'b0, 2'b10, 6'b101010, 5'd0, 32'h80000000, 32'h1, 1'b0, 1'b0, 32'h0);
    checkAlu("slt_ovf_true", 4'b0111, 32'h1, 8'h00);
    applyStimulus(1'b0, 2'b10, 6'b101010, 5'd0, 32'h7FFFFFFF, 32'h80000000, 1'b0, 1'b0, 32'h0);
    checkAlu("slt_ovf_false", 4'b0111, 32'h0, 8'h80);

    applyStimulus(1'b0, 2'b10, 6'b100111, 5'd0, 32'h0, 32'h0F0F0F0F, 1'b0, 1'b0, 32'h0);
    checkAlu("nor", 4'b1100, 32'hF0F0F0F0, 8'h40);
    applyStimulus(1'b0, 2'b10, 6'b100100, 5'd0, 32'hFF00FF00, 32'h0F0F0F0F, 1'b0, 1'b0, 32'h0);
    checkAlu("and", 4'b0000, 32'h0F000F00, 8'h00);
    applyStimulus(1'b0, 2'b11, 6'd0, 5'd0, 32'hF0, 32'h0F, 1'b0, 1'b0, 32'h0);
    checkAlu("ori", 4'b0001, 32'hFF, 8'h00);
    applyStimulus(1'b0, 2'b10, 6'b111111, 5'd0, 32'h12, 32'h34, 1'b0, 1'b0, 32'h0);
    checkAlu("invalid", 4'b1111, 32'h0, 8'h88);

    applyStimulus(1'b0, 2'b00, 6'd0, 5'd0, 32'h10, 32'h4, 1'b1, 1'b1, 32'hDEADBEEF);
    checkOutput("rdw_old_word", read_data, 32'h0);
    applyStimulus(1'b0, 2'b00, 6'd0, 5'd0, 32'h10, 32'h4, 1'b0, 1'b1, 32'h0);
    checkOutput("load_0x14", read_data, 32'hDEADBEEF);
    applyStimulus(1'b0, 2'b00, 6'd0, 5'd0, 32'h10, 32'h7, 1'b0, 1'b1, 32'h0);
    checkOutput("load_0x17", read_data, 32'hDEADBEEF);
    applyStimulus(1'b0, 2'b00, 6'd0, 5'd0, 32'h10, 32'h4, 1'b0, 1'b0, 32'h0);
    checkOutput("load_disabled", read_data, 32'h0);

    applyStimulus(1'b0, 2'b00, 6'd0, 5'd0, 32'h100, 32'h0, 1'b1, 1'b0, 32'h11112222);
    applyStimulus(1'b0, 2'b00, 6'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0);
    checkOutput("wrap_alias_idx0", read_data, 32'h11112222);
    applyStimulus(1'b0, 2'b00, 6'd0, 5'd0, 32'h14, 32'h0, 1'b0, 1'b1, 32'h0);
    checkOutput("wrap_no_clobber", read_data, 32'hDEADBEEF);

    applyStimulus(1'b1, 2'b00, 6'd0, 5'd0, 32'hC, 32'h0, 1'b1, 1'b1, 32'hCAFE0001);
    checkOutput("reset_held_read", read_data, 32'h0);
    applyStimulus(1'b0, 2'b00, 6'd0, 5'd0, 32'hC, 32'h0, 1'b0, 1'b1, 32'h0);
    checkOutput("reset_beats_write", read_data, 32'h0);
    applyStimulus(1'b0, 2'b00, 6'd0, 5'd0, 32'h14, 32'h0, 1'b0, 1'b1, 32'h0);
    checkOutput("reset_cleared_idx5", read_data, 32'h0);

    applyStimulus(1'b0, 2'b10, 6'b000000, 5'd31, 32'h0, 32'h1, 1'b0, 1'b0, 32'h0);
`ifdef ALU_SHIFT_EN
    checkAlu("sll", 4'b1000, 32'h80000000, 8'h40);
`else
    checkAlu("sll_disabled", 4'b1111, 32'h0, 8'h88);
`endif
    applyStimulus(1'b0, 2'b10, 6'b000010, 5'd4, 32'h0, 32'h80000000, 1'b0, 1'b0, 32'h0);
`ifdef ALU_SHIFT_EN
    checkAlu("srl", 4'b1001, 32'h08000000, 8'h00);
`else
    checkAlu("srl_disabled", 4'b1111, 32'h0, 8'h88);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
